// File: rtl/fifo_uart_tx.sv
// UART transmitter draining the async FIFO read port in the r_clk domain.
// Optional parity bit compiled in with `define UART_TX_PARITY_EN.
module fifo_uart_tx #(
  parameter int f_width      = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic               r_clk,
  input  logic               reset_n,
  input  logic               tx_en,
  input  logic               f_empty_flag,
  input  logic [f_width-1:0] d_out,
  output logic               r_en,
  output logic               tx,
  output logic               busy,
  output logic               tx_done
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(f_width + 1);
  localparam logic [CW-1:0] RELOAD = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] LAST_D = BW'(f_width - 1);
  localparam logic [BW-1:0] LAST_S = BW'(STOP_BITS - 1);

`ifdef UART_TX_PARITY_EN
  localparam bit HAS_PAR = 1'b1;
`else
  localparam bit HAS_PAR = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, DATA, PARITY, STOP
  } state_t;

  state_t state, nxt;

  logic [CW-1:0]      baud;
  logic [BW-1:0]      bits;
  logic [f_width-1:0] shreg, shreg_n;
  logic               par;
  logic               tick, last_d, last_s;
  logic               tx_n, r_en_n, busy_n, done_n;

  assign tick   = (baud == '0);
  assign last_d = (bits == LAST_D);
  assign last_s = (bits == LAST_S);

  always_ff @(posedge r_clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:    if (tx_en && !f_empty_flag) nxt = FETCH;
      FETCH:   nxt = LOAD;
      LOAD:    nxt = START;
      START:   if (tick) nxt = DATA;
      DATA:    if (tick && last_d) nxt = HAS_PAR ? PARITY : STOP;
      PARITY:  if (tick) nxt = STOP;
      STOP:    if (tick && last_s) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Outputs are computed for the next state so they can be registered.
  always_comb begin
    shreg_n = shreg;
    if (state == DATA && tick) shreg_n = shreg >> 1;
    tx_n = 1'b1;
    unique case (nxt)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shreg_n[0];
      PARITY:  tx_n = par;
      default: tx_n = 1'b1;
    endcase
    r_en_n = (nxt == FETCH);
    busy_n = (nxt != IDLE);
    done_n = (state == STOP) && (nxt == IDLE);
  end

  always_ff @(posedge r_clk or negedge reset_n) begin
    if (!reset_n) begin
      baud  <= '0;
      bits  <= '0;
      shreg <= '0;
      par   <= 1'b0;
    end else if (state == LOAD) begin
      baud  <= RELOAD;
      bits  <= '0;
      shreg <= d_out;
      par   <= ^d_out ^ PARITY_ODD;
    end else if (state inside {START, DATA, PARITY, STOP}) begin
      baud  <= tick ? RELOAD : baud - 1'b1;
      shreg <= shreg_n;
      if (tick && state == DATA) bits <= last_d ? '0 : bits + 1'b1;
      if (tick && state == STOP) bits <= last_s ? '0 : bits + 1'b1;
    end
  end

  always_ff @(posedge r_clk or negedge reset_n) begin
    if (!reset_n) begin
      tx      <= 1'b1;
      r_en    <= 1'b0;
      busy    <= 1'b0;
      tx_done <= 1'b0;
    end else begin
      tx      <= tx_n;
      r_en    <= r_en_n;
      busy    <= busy_n;
      tx_done <= done_n;
    end
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Self-checking bench for fifo_uart_tx: FIFO model, frame-level model,
// directed literal checks and randomized traffic.
module tb_fifo_uart_tx;

  localparam int W   = 8;
  localparam int CPB = 4;
  localparam int SB  = 1;
`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB = 1 + W + P + SB;

  logic         r_clk = 1'b0;
  logic         reset_n = 1'b1;
  logic         tx_en = 1'b0;
  logic         f_empty_flag = 1'b1;
  logic [W-1:0] d_out = '0;
  logic         r_en, tx, busy, tx_done;

  fifo_uart_tx #(
    .f_width(W), .CLKS_PER_BIT(CPB),
    .STOP_BITS(SB), .PARITY_ODD(1'b0)
  ) dut (
    .r_clk(r_clk), .reset_n(reset_n),
    .tx_en(tx_en), .f_empty_flag(f_empty_flag),
    .d_out(d_out), .r_en(r_en), .tx(tx),
    .busy(busy), .tx_done(tx_done)
  );

  always #5 r_clk = ~r_clk;

  int n_tot = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] a,
                     input logic [31:0] e);
    n_tot++;
    if (a === e) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at t=%0t",
                  nm, a, e, $time);
  endtask

  // FIFO: data appears after the r_en cycle and is garbage otherwise.
  logic [W-1:0] fq[$];
  logic [W-1:0] eq[$];
  bit hold = 1'b0;
  always @(negedge r_clk) begin
    if (r_en && fq.size() > 0) begin
      d_out = fq.pop_front();
      hold = 1'b1;
    end else if (hold) begin
      hold = 1'b0;
    end else begin
      d_out = W'($urandom);
    end
    f_empty_flag = (fq.size() == 0);
  end

  task automatic push(input logic [W-1:0] w);
    fq.push_back(w);
    eq.push_back(w);
  endtask

  function automatic logic [NB-1:0] frame(input logic [W-1:0] w);
    logic [NB-1:0] f;
    f = '1;
    f[0] = 1'b0;
    for (int i = 0; i < W; i++) f[1+i] = w[i];
    if (P == 1) f[1+W] = ^w;
    for (int i = NB - SB; i < NB; i++) f[i] = 1'b1;
    return f;
  endfunction

  // Model: c counts cycles since FETCH; -1 means idle.
  int c = -1;
  logic m_done = 1'b0;
  logic [NB-1:0] fbits = '1;
  always @(posedge r_clk or negedge reset_n) begin
    if (!reset_n) begin
      c = -1;
      m_done = 1'b0;
    end else if (c < 0) begin
      m_done = 1'b0;
      if (tx_en && !f_empty_flag && eq.size() > 0) begin
        fbits = frame(eq.pop_front());
        c = 0;
      end
    end else begin
      m_done = 1'b0;
      c++;
      if (c == 2 + NB * CPB) begin
        c = -1;
        m_done = 1'b1;
      end
    end
  end

  always @(negedge r_clk) begin
    if (chk_en) begin
      chk("tx", tx, (c >= 2) ? fbits[(c-2)/CPB] : 1'b1);
      chk("r_en", r_en, c == 0);
      chk("busy", busy, c >= 0);
      chk("tx_done", tx_done, m_done);
    end
  end

  // Monitor for directed checks.
  int cyc = 0;
  int ren_cnt = 0, ren_cyc = 0;
  int done_cnt = 0, done_cyc = 0;
  int fall_q[$];
  int done_q[$];
  logic prev_tx = 1'b1;
  logic txlog [0:32767];
  always @(negedge r_clk) begin
    cyc++;
    if (cyc < 32768) txlog[cyc] = tx;
    if (r_en) begin
      ren_cnt++;
      ren_cyc = cyc;
    end
    if (prev_tx && !tx) fall_q.push_back(cyc);
    prev_tx = tx;
    if (tx_done) begin
      done_cnt++;
      done_cyc = cyc;
      done_q.push_back(cyc);
    end
  end

  task automatic step();
    @(negedge r_clk);
    #2;
  endtask

  task automatic wait_done(input int target, input int lim);
    int i = 0;
    while (done_cnt < target && i < lim) begin
      step();
      i++;
    end
    chk("wait_done", done_cnt >= target, 1);
  endtask

  task automatic wait_fall(input int n, input int lim);
    int i = 0;
    while (fall_q.size() <= n && i < lim) begin
      step();
      i++;
    end
    chk("wait_fall", fall_q.size() > n, 1);
  endtask

  int r0, d0, f0, fs, rel, cnt;
  logic [NB-1:0] exp_a5;

  initial begin
`ifdef UART_TX_PARITY_EN
    exp_a5 = 11'b10101001010;
`else
    exp_a5 = 10'b1101001010;
`endif
    #1 reset_n = 1'b0;
    chk_en = 1'b1;
    #1;
    chk("rst_tx", tx, 1);
    chk("rst_ren", r_en, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", tx_done, 0);
    repeat (3) @(negedge r_clk);
    #1 reset_n = 1'b1;

    // Empty FIFO: never read.
    tx_en = 1'b1;
    r0 = ren_cnt;
    repeat (200) step();
    chk("empty_ren", ren_cnt - r0, 0);
    chk("empty_tx", tx, 1);
    chk("empty_busy", busy, 0);

    // Single word 0xA5.
    r0 = ren_cnt; d0 = done_cnt; f0 = fall_q.size();
    push(8'hA5);
    wait_done(d0 + 1, 200);
    wait_fall(f0, 1);
    if (fall_q.size() > f0) begin
      fs = fall_q[f0];
      chk("a5_ren", ren_cnt - r0, 1);
      chk("a5_lat", fs - ren_cyc, 2);
      chk("a5_len", done_cyc - fs, NB * CPB);
      for (int k = 0; k < NB; k++)
        chk("a5_bit", txlog[fs + CPB*k + 2], exp_a5[k]);
    end
    repeat (5) step();
    chk("a5_done", done_cnt - d0, 1);

    // Back-to-back 0x00 then 0xFF.
    r0 = ren_cnt; d0 = done_cnt; f0 = fall_q.size();
    push(8'h00);
    push(8'hFF);
    wait_done(d0 + 2, 300);
    wait_fall(f0 + 1, 1);
    chk("b2b_ren", ren_cnt - r0, 2);
    if (fall_q.size() > f0 + 1 && done_q.size() > d0) begin
      chk("b2b_gap", fall_q[f0+1] - done_q[d0], 3);
      cnt = 0;
      for (int i = done_q[d0]; i < fall_q[f0+1]; i++)
        cnt += int'(txlog[i]);
      chk("b2b_ones", cnt, 3);
    end

    // Word 0x07: parity (if built) or stop at bit 9.
    d0 = done_cnt; f0 = fall_q.size();
    push(8'h07);
    wait_done(d0 + 1, 200);
    wait_fall(f0, 1);
    if (fall_q.size() > f0) begin
      fs = fall_q[f0];
      chk("w07_len", done_cyc - fs, NB * CPB);
      chk("w07_b8", txlog[fs + CPB*8 + 2], 0);
      chk("w07_b9", txlog[fs + CPB*9 + 2], 1);
    end

    // Reset during data bit 3, FIFO still holding a word.
    d0 = done_cnt; f0 = fall_q.size();
    push(8'h5A);
    push(8'hC3);
    wait_fall(f0, 50);
    if (fall_q.size() > f0) begin
      fs = fall_q[f0];
      for (int i = 0; i < 100 && cyc < fs + 17; i++) step();
      reset_n = 1'b0;
      #1;
      chk("mid_rst_tx", tx, 1);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_ren", r_en, 0);
      chk("mid_rst_done", tx_done, 0);
      repeat (2) @(negedge r_clk);
      #1 reset_n = 1'b1;
      rel = cyc;
      chk("mid_rst_nodone", done_cnt - d0, 0);
      step();
      chk("refetch", ren_cyc, rel + 1);
      wait_done(d0 + 1, 200);
    end

    // Randomized traffic with tx_en toggling.
    for (int it = 0; it < 40; it++) begin
      tx_en = ($urandom_range(0, 3) != 0);
      for (int n = $urandom_range(0, 3); n > 0; n--)
        push(W'($urandom));
      repeat ($urandom_range(0, 120)) @(negedge r_clk);
      #1;
    end
    tx_en = 1'b1;
    cnt = 0;
    while ((fq.size() > 0 || busy) && cnt < 3000) begin
      step();
      cnt++;
    end
    chk("drain", (fq.size() == 0) && !busy, 1);
    repeat (10) step();

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
